// File: rtl/ex_div_stage_if.sv
// EX-stage bundle: ID/EX operands and flush in, EX/MEM result, HI/LO strobe and stall request out.
interface ex_div_stage_if #(
  parameter int DATA_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int ADDR_W   = 5
);
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [ALUSEL_W-1:0] ex_alusel;
  logic [DATA_W-1:0]   ex_reg1;
  logic [DATA_W-1:0]   ex_reg2;
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic                annul_i;
  logic [ADDR_W-1:0]   wd_o;
  logic                wreg_o;
  logic [DATA_W-1:0]   wdata_o;
  logic                whilo_o;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;
  logic                stallreq_o;

  modport master (
    output ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, annul_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, annul_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_div_stage.sv
// EX stage: logic/add/sub/slt resolve in 0 cycles; DIV/DIVU use a restoring divider, stall for 1+DATA_W cycles
// (1 for a zero divisor) and strobe HI/LO in the following cycle; annul_i drops the stall at once.
module ex_div_stage #(
  parameter int DATA_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int ADDR_W   = 5
) (
  input logic           clk,
  input logic           rst,
  ex_div_stage_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(8'h24);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8'h25);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(8'h26);
  localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(8'h27);
  localparam logic [ALUOP_W-1:0] OP_ADDU = ALUOP_W'(8'h21);
  localparam logic [ALUOP_W-1:0] OP_SUBU = ALUOP_W'(8'h23);
  localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8'h2A);
  localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(8'h1A);
  localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(8'h1B);

  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3'b100);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic              neg_q;
  logic              neg_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  logic              is_div;
  logic              is_signed;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              step_ok;
  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quot;
  logic [DATA_W-1:0] fin_q;
  logic [DATA_W-1:0] fin_r;
  logic              last_step;
  logic [DATA_W-1:0] wdata;

  assign is_div    = (bus.ex_aluop == OP_DIV) || (bus.ex_aluop == OP_DIVU);
  assign is_signed = (bus.ex_aluop == OP_DIV);
  assign abs_a     = (is_signed && bus.ex_reg1[DATA_W-1]) ? -bus.ex_reg1 : bus.ex_reg1;
  assign abs_b     = (is_signed && bus.ex_reg2[DATA_W-1]) ? -bus.ex_reg2 : bus.ex_reg2;

  // One restoring step: remainder stays below the divisor, so DATA_W+1 bits hold the trial difference.
  assign shifted   = {rem, quot[DATA_W-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign step_ok   = ~diff[DATA_W];
  assign step_rem  = step_ok ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign step_quot = {quot[DATA_W-2:0], step_ok};
  assign fin_q     = neg_q ? -step_quot : step_quot;
  assign fin_r     = neg_r ? -step_rem : step_rem;
  assign last_step = (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      quot  <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else if (bus.annul_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            neg_q <= is_signed && (bus.ex_reg1[DATA_W-1] ^ bus.ex_reg2[DATA_W-1]);
            neg_r <= is_signed && bus.ex_reg1[DATA_W-1];
            quot  <= abs_a;
            dvs   <= abs_b;
            rem   <= '0;
            cnt   <= '0;
            if (bus.ex_reg2 == '0) begin
              // Zero divisor skips iteration: HI gets the raw dividend, LO all ones.
              hi_r  <= bus.ex_reg1;
              lo_r  <= '1;
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem  <= step_rem;
          quot <= step_quot;
          cnt  <= cnt + CNT_W'(1);
          if (last_step) begin
            hi_r  <= fin_r;
            lo_r  <= fin_q;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wdata = '0;
    case (bus.ex_alusel)
      SEL_LOGIC: begin
        case (bus.ex_aluop)
          OP_AND:  wdata = bus.ex_reg1 & bus.ex_reg2;
          OP_OR:   wdata = bus.ex_reg1 | bus.ex_reg2;
          OP_XOR:  wdata = bus.ex_reg1 ^ bus.ex_reg2;
          OP_NOR:  wdata = ~(bus.ex_reg1 | bus.ex_reg2);
          default: wdata = '0;
        endcase
      end
      SEL_ARITH: begin
        case (bus.ex_aluop)
          OP_ADDU: wdata = bus.ex_reg1 + bus.ex_reg2;
          OP_SUBU: wdata = bus.ex_reg1 - bus.ex_reg2;
          OP_SLT:  wdata = {{(DATA_W-1){1'b0}}, ($signed(bus.ex_reg1) < $signed(bus.ex_reg2))};
          default: wdata = '0;
        endcase
      end
      default: wdata = '0;
    endcase
  end

  assign bus.wd_o       = rst ? bus.ex_wd : '0;
  assign bus.wreg_o     = rst && bus.ex_wreg && !is_div;
  assign bus.wdata_o    = rst ? wdata : '0;
  assign bus.whilo_o    = rst && (state == S_DONE) && !bus.annul_i;
  assign bus.hi_o       = hi_r;
  assign bus.lo_o       = lo_r;
  assign bus.stallreq_o = rst && !bus.annul_i &&
                          (((state == S_IDLE) && is_div) || (state == S_BUSY));
endmodule

// File: tb/tb_ex_div_stage.sv
// Scoreboard bench for ex_div_stage: directed ALU and divide vectors, stall-length and HI/LO checks.
module tb_ex_div_stage;
  localparam int W = 32;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef struct {
    logic [W-1:0] wdata;
    logic         wreg;
    logic [4:0]   wd;
    logic         stall;
    string        name;
  } comb_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } divexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_div_stage_if #(.DATA_W(W)) bus ();
  ex_div_stage #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  comb_t   comb_q[$];
  divexp_t div_q[$];
  int      stall_q[$];
  int      checks = 0;
  int      failures = 0;
  logic    comb_vld = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result or ends a stall run.
  comb_t   ce;
  divexp_t de;
  int      run = 0;
  always @(negedge clk) begin
    if (comb_vld) begin
      if (comb_q.size() == 0) chk("comb_q_underflow", 1, 0);
      else begin
        ce = comb_q.pop_front();
        chk({ce.name, "_wdata"}, bus.wdata_o, ce.wdata);
        chk({ce.name, "_wreg"}, 32'(bus.wreg_o), 32'(ce.wreg));
        chk({ce.name, "_wd"}, 32'(bus.wd_o), 32'(ce.wd));
        chk({ce.name, "_stall"}, 32'(bus.stallreq_o), 32'(ce.stall));
      end
    end
    if (bus.whilo_o) begin
      if (div_q.size() == 0) chk("whilo_unexpected", 1, 0);
      else begin
        de = div_q.pop_front();
        chk({de.name, "_hi"}, bus.hi_o, de.hi);
        chk({de.name, "_lo"}, bus.lo_o, de.lo);
      end
    end
    if (bus.stallreq_o) run++;
    else if (run > 0) begin
      if (stall_q.size() == 0) chk("stall_unexpected", run, 0);
      else chk("stall_len", run, stall_q.pop_front());
      run = 0;
    end
  end

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] wd, input logic wreg);
    bus.ex_aluop  = op;
    bus.ex_alusel = sel;
    bus.ex_reg1   = a;
    bus.ex_reg2   = b;
    bus.ex_wd     = wd;
    bus.ex_wreg   = wreg;
  endtask

  task automatic comb_op(input string name, input logic [7:0] op, input logic [2:0] sel,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] wd,
                         input logic wreg, input logic [W-1:0] exp);
    comb_t e;
    @(posedge clk); #1;
    drive(op, sel, a, b, wd, wreg);
    e.wdata = exp; e.wreg = wreg; e.wd = wd; e.stall = 1'b0; e.name = name;
    comb_q.push_back(e);
    comb_vld = 1'b1;
    @(posedge clk); #1;
    comb_vld = 1'b0;
    drive(OP_NOP, SEL_NOP, '0, '0, '0, 1'b0);
  endtask

  task automatic div_op(input string name, input logic [7:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int estall, input bit scramble);
    comb_t   e;
    divexp_t d;
    int      n;
    @(posedge clk); #1;
    drive(op, SEL_NOP, a, b, 5'd9, 1'b1);
    e.wdata = '0; e.wreg = 1'b0; e.wd = 5'd9; e.stall = 1'b1; e.name = {name, "_issue"};
    comb_q.push_back(e);
    d.hi = ehi; d.lo = elo; d.name = name;
    div_q.push_back(d);
    stall_q.push_back(estall);
    comb_vld = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      comb_vld = 1'b0;
      n++;
      if (scramble) begin
        bus.ex_reg1 = $urandom;
        bus.ex_reg2 = $urandom;
      end
    end while (bus.stallreq_o && n < 100);
    if (n >= 100) chk({name, "_timeout"}, 1, 0);
    @(posedge clk); #1;
    drive(OP_NOP, SEL_NOP, '0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.annul_i = 1'b0;
    drive(OP_AND, SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
    #2;
    chk("rst_wdata", bus.wdata_o, 0);
    chk("rst_wd", 32'(bus.wd_o), 0);
    chk("rst_wreg", 32'(bus.wreg_o), 0);
    chk("rst_stall", 32'(bus.stallreq_o), 0);
    chk("rst_whilo", 32'(bus.whilo_o), 0);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    drive(OP_NOP, SEL_NOP, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    comb_op("and",   OP_AND,  SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd3, 1'b1, 32'h00F0_000F);
    comb_op("or",    OP_OR,   SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd4, 1'b1, 32'hFFF0_0FFF);
    comb_op("xor",   OP_XOR,  SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd5, 1'b0, 32'hFF00_0FF0);
    comb_op("nor",   OP_NOR,  SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd31, 1'b1, 32'h000F_F000);
    comb_op("addu",  OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 1'b1, 32'h0000_0001);
    comb_op("subu",  OP_SUBU, SEL_ARITH, 32'h0000_0005, 32'h0000_0007, 5'd2, 1'b1, 32'hFFFF_FFFE);
    comb_op("slt_a", OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1, 32'h0000_0001);
    comb_op("slt_b", OP_SLT,  SEL_ARITH, 32'h0000_0001, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h0000_0000);
    comb_op("slt_c", OP_SLT,  SEL_ARITH, 32'h8000_0000, 32'h7FFF_FFFF, 5'd8, 0, 32'h0000_0001);
    comb_op("selnop", OP_AND, SEL_NOP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0);
    comb_op("badop", OP_AND,  SEL_ARITH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h0);

    div_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
    div_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    div_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 1'b1);
    div_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);
    div_op("divu_max",   OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 33, 1'b0);
    div_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1'b1);
    div_op("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 1'b0);

    // Flush at BUSY cycle 10: stall drops in that cycle, no HI/LO strobe follows.
    @(posedge clk); #1;
    drive(OP_DIV, SEL_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
    stall_q.push_back(10);
    repeat (10) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    #1 chk("annul_stall_now", 32'(bus.stallreq_o), 0);
    chk("annul_whilo_now", 32'(bus.whilo_o), 0);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    drive(OP_NOP, SEL_NOP, '0, '0, '0, 1'b0);
    repeat (40) @(posedge clk);

    // Reset at BUSY cycle 20 while a new divide is in flight.
    @(posedge clk); #1;
    drive(OP_DIVU, SEL_NOP, 32'd12345, 32'd11, 5'd9, 1'b1);
    stall_q.push_back(20);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    drive(OP_OR, SEL_LOGIC, 32'h1234_5678, 32'h0F0F_0F0F, 5'd17, 1'b1);
    #1;
    chk("midrst_wdata", bus.wdata_o, 0);
    chk("midrst_wd", 32'(bus.wd_o), 0);
    chk("midrst_wreg", 32'(bus.wreg_o), 0);
    chk("midrst_stall", 32'(bus.stallreq_o), 0);
    chk("midrst_whilo", 32'(bus.whilo_o), 0);
    chk("midrst_hi", bus.hi_o, 0);
    chk("midrst_lo", bus.lo_o, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(OP_NOP, SEL_NOP, '0, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (40) @(posedge clk);

    comb_op("post_rst_addu", OP_ADDU, SEL_ARITH, 32'd40, 32'd2, 5'd12, 1'b1, 32'd42);
    div_op("post_rst_divu", OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1, 1'b0);
    div_op("post_rst_div",  OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("div_q_left", div_q.size(), 0);
    chk("stall_q_left", stall_q.size(), 0);
    chk("comb_q_left", comb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
